jstk2_spi_responder: RTL and testbench

- SPI mode-0 slave that emulates the JSTK2 joystick module at the far end of the PMOD SPI link.
- Returns a 5-byte frame per chip-select: X low, X high, Y low, Y high, buttons.
- Captures master-sent bytes and decodes the set-LED command into a latched RGB value.
- Serves as the device model for closed-loop benches of our joystick poller, and as the responder on a second FPGA that stands in for the PMOD.

---
 rtl/jstk2_pkg.sv | 38 +++
 rtl/jstk2_spi_responder_if.sv | 11 +
 rtl/spi_sync_edge.sv | 35 +++
 rtl/jstk2_spi_responder.sv | 165 ++++++++++++++++
 tb/tb_jstk2_spi_responder.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/jstk2_pkg.sv
// Shared JSTK2 constants: command codes, frame layout and responder state encoding.
package jstk2_pkg;

    localparam logic [7:0] JSTK2_CMD_SET_LED = 8'h84;
    localparam int         JSTK2_FRAME_BYTES = 5;

    // Byte positions inside one chip-select frame.
    localparam int IDX_XL  = 0;
    localparam int IDX_XH  = 1;
    localparam int IDX_YL  = 2;
    localparam int IDX_YH  = 3;
    localparam int IDX_BTN = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } jstk2_state_e;

    // Byte returned at position idx; anything at or past n_bytes reads as zero.
    function automatic logic [7:0] jstk2_frame_byte(input int idx, input int n_bytes,
                                                    input logic [9:0] x, input logic [9:0] y,
                                                    input logic [7:0] btn);
        logic [7:0] b;
        b = 8'h00;
        if (idx < n_bytes) begin
            case (idx)
                IDX_XL:  b = x[7:0];
                IDX_XH:  b = {6'b0, x[9:8]};
                IDX_YL:  b = y[7:0];
                IDX_YH:  b = {6'b0, y[9:8]};
                IDX_BTN: b = btn;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/jstk2_spi_responder_if.sv
// PMOD SPI pins between a JSTK2 poller (master) and the responder (slave).
interface jstk2_spi_responder_if;
    logic sck;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sck, output cs_n, output mosi, input miso, input miso_oe);
    modport slave  (input sck, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with one history flop; rise/fall are one-cycle pulses
// derived only from the synchronized copy.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe;
    logic              hist;

    // Shift the raw input through the synchronizer chain and keep one history bit.
    // NOTE: non-blocking assignments make every flop sample the pre-edge value,
    // so the chain really is STAGES+1 registers deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= {STAGES{RESET_VAL}};
            hist <= RESET_VAL;
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
            hist <= pipe[STAGES-1];
        end
    end

    assign sync = pipe[STAGES-1];
    assign rise = sync & ~hist;
    assign fall = ~sync & hist;

endmodule

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 slave emulating the JSTK2 joystick: 5-byte position/button frame
// out on MISO, MOSI bytes captured, set-LED command decoded into an RGB latch.
module jstk2_spi_responder
    import jstk2_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         FRAME_BYTES = JSTK2_FRAME_BYTES,
    parameter logic [7:0] CMD_SET_LED = JSTK2_CMD_SET_LED
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    jstk2_spi_responder_if.slave  spi,
    input  logic [9:0]            i_X_Pos,
    input  logic [9:0]            i_Y_Pos,
    input  logic [7:0]            i_Buttons,
    output logic [7:0]            o_RX_Byte,
    output logic                  o_RX_DV,
    output logic [23:0]           o_LED_RGB,
    output logic                  o_Frame_Done
);

    localparam int IDX_W = $clog2(FRAME_BYTES + 1);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(i_Clk), .rst_n(i_Rst_L), .d(spi.sck),
        .sync(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    // CS_n resets to the deselected level so reset release alone never starts a frame.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(i_Clk), .rst_n(i_Rst_L), .d(spi.cs_n),
        .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(i_Clk), .rst_n(i_Rst_L), .d(spi.mosi),
        .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Levels of SCK/CS_n and MOSI edges are not needed; only edges and MOSI level are.
    logic unused_sync;
    assign unused_sync = ^{sck_s, cs_s, mosi_rise, mosi_fall};

    jstk2_state_e state_q, state_d;
    logic         start_frame, end_frame, bit_rise, bit_fall;

    logic [9:0]       snap_x, snap_y;
    logic [7:0]       snap_btn;
    logic [7:0]       tx_shift, rx_shift, cmd_q;
    logic [2:0]       bit_cnt;
    logic [IDX_W-1:0] byte_idx;
    logic [15:0]      led_stage;
    logic             miso_q, oe_q;

    logic [7:0] rx_next, first_byte, next_byte;
    assign rx_next    = {rx_shift[6:0], mosi_s};
    assign first_byte = jstk2_frame_byte(0, FRAME_BYTES, i_X_Pos, i_Y_Pos, i_Buttons);
    assign next_byte  = jstk2_frame_byte(int'(byte_idx), FRAME_BYTES, snap_x, snap_y, snap_btn);

    assign spi.miso    = miso_q;
    assign spi.miso_oe = oe_q;

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and event qualification; a CS_n rise masks any SCK edge in the same cycle.
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        bit_rise    = 1'b0;
        bit_fall    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    end_frame = 1'b1;
                end else begin
                    bit_rise = sck_rise;
                    bit_fall = sck_fall;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame datapath: snapshot, TX/RX shifters, byte bookkeeping and command decode.
    // NOTE: snapshot and staging registers are reset too, so a reset mid-frame
    // leaves nothing from the old frame visible.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            snap_x       <= '0;
            snap_y       <= '0;
            snap_btn     <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            cmd_q        <= '0;
            bit_cnt      <= '0;
            byte_idx     <= '0;
            led_stage    <= '0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            o_RX_Byte    <= '0;
            o_RX_DV      <= 1'b0;
            o_LED_RGB    <= '0;
            o_Frame_Done <= 1'b0;
        end else begin
            o_RX_DV      <= 1'b0;
            o_Frame_Done <= 1'b0;
            if (start_frame) begin
                snap_x   <= i_X_Pos;
                snap_y   <= i_Y_Pos;
                snap_btn <= i_Buttons;
                tx_shift <= first_byte;
                miso_q   <= first_byte[7];
                oe_q     <= 1'b1;
                rx_shift <= '0;
                bit_cnt  <= '0;
                byte_idx <= '0;
            end else if (end_frame) begin
                oe_q         <= 1'b0;
                miso_q       <= 1'b0;
                bit_cnt      <= '0;
                o_Frame_Done <= (byte_idx != '0);
            end else if (bit_rise) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    o_RX_Byte <= rx_next;
                    o_RX_DV   <= 1'b1;
                    if (int'(byte_idx) < FRAME_BYTES) byte_idx <= byte_idx + IDX_W'(1);
                    if (int'(byte_idx) == 0) cmd_q <= rx_next;
                    if (cmd_q == CMD_SET_LED) begin
                        if (int'(byte_idx) == 1) led_stage[15:8] <= rx_next;
                        if (int'(byte_idx) == 2) led_stage[7:0]  <= rx_next;
                        if (int'(byte_idx) == 3) o_LED_RGB       <= {led_stage, rx_next};
                    end
                end
            end else if (bit_fall) begin
                if (bit_cnt == 3'd0) begin
                    tx_shift <= next_byte;
                    miso_q   <= next_byte[7];
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    miso_q   <= tx_shift[6];
                end
            end
        end
    end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Directed bench: the initial block acts as a mode-0 SPI master (24 clocks/bit).
module tb_jstk2_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic [7:0]  buttons = '0;
    logic [7:0]  rx_byte;
    logic        rx_dv;
    logic [23:0] led_rgb;
    logic        frame_done;

    int n_cmp = 0;
    int n_fail = 0;

    jstk2_spi_responder_if spi ();

    jstk2_spi_responder dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .spi(spi.slave),
        .i_X_Pos(x_pos), .i_Y_Pos(y_pos), .i_Buttons(buttons),
        .o_RX_Byte(rx_byte), .o_RX_DV(rx_dv), .o_LED_RGB(led_rgb),
        .o_Frame_Done(frame_done)
    );

    always #20 clk = ~clk;

    // Pulse monitors: log every RX_DV byte and count Frame_Done pulses.
    logic [7:0] rx_log [64];
    int         rx_cnt = 0;
    int         done_cnt = 0;
    always @(negedge clk) begin
        if (rx_dv) begin
            rx_log[rx_cnt % 64] <= rx_byte;
            rx_cnt <= rx_cnt + 1;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi.cs_n = 1'b0;
        wait_clks(12);
    endtask

    task automatic cs_high();
        wait_clks(12);
        spi.cs_n = 1'b1;
        wait_clks(12);
    endtask

    // Clock nbits of tx (MSB first); MISO is sampled just before each SCK rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = tx[7-i];
            wait_clks(12);
            rx[7-i] = spi.miso;
            spi.sck = 1'b1;
            wait_clks(12);
            spi.sck = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rx;
        int         rx_base, done_base;
        logic [7:0] exp_basic [5];
        logic [7:0] exp_led [5];
        logic [7:0] exp_over [7];
        exp_basic = '{8'hA5, 8'h02, 8'h3C, 8'h01, 8'h03};
        exp_led   = '{8'h84, 8'h11, 8'h22, 8'h33, 8'h00};
        exp_over  = '{8'h01, 8'h00, 8'h3C, 8'h01, 8'h03, 8'h00, 8'h00};

        spi.sck = 1'b0; spi.cs_n = 1'b1; spi.mosi = 1'b0;

        // Reset state
        wait_clks(5);
        check("rst_miso", spi.miso, 1'b0);
        check("rst_oe", spi.miso_oe, 1'b0);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_rx_dv", rx_dv, 1'b0);
        check("rst_led", led_rgb, 24'h0);
        check("rst_done", frame_done, 1'b0);
        rst_n = 1'b1;
        wait_clks(5);

        // Basic read
        x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 8'h03;
        rx_base = rx_cnt; done_base = done_cnt;
        cs_low();
        check("basic_oe_active", spi.miso_oe, 1'b1);
        for (int b = 0; b < 5; b++) begin
            xfer(8'h00, 8, rx);
            check($sformatf("basic_byte%0d", b), rx, exp_basic[b]);
        end
        cs_high();
        check("basic_done_cnt", done_cnt - done_base, 1);
        check("basic_rxdv_cnt", rx_cnt - rx_base, 5);
        check("basic_oe_idle", spi.miso_oe, 1'b0);
        check("basic_miso_idle", spi.miso, 1'b0);
        check("basic_led_untouched", led_rgb, 24'h0);

        // Snapshot: X changes after byte 0
        cs_low();
        xfer(8'h00, 8, rx);
        check("snap_byte0", rx, 8'hA5);
        x_pos = 10'h001;
        xfer(8'h00, 8, rx);
        check("snap_byte1_old", rx, 8'h02);
        for (int b = 2; b < 5; b++) xfer(8'h00, 8, rx);
        cs_high();
        cs_low();
        xfer(8'h00, 8, rx);
        check("snap_next_byte0", rx, 8'h01);
        xfer(8'h00, 8, rx);
        check("snap_next_byte1", rx, 8'h00);
        cs_high();

        // LED command
        rx_base = rx_cnt;
        cs_low();
        for (int b = 0; b < 5; b++) xfer(exp_led[b], 8, rx);
        cs_high();
        check("led_rgb", led_rgb, 24'h112233);
        check("led_rxdv_cnt", rx_cnt - rx_base, 5);
        for (int b = 0; b < 5; b++)
            check($sformatf("led_rx%0d", b), rx_log[(rx_base + b) % 64], exp_led[b]);

        // Non-LED command leaves the RGB latch alone
        cs_low();
        xfer(8'h10, 8, rx);
        for (int b = 0; b < 3; b++) xfer(8'h99, 8, rx);
        cs_high();
        check("other_cmd_led", led_rgb, 24'h112233);

        // Aborted LED command after 4 bits of byte 2
        rx_base = rx_cnt; done_base = done_cnt;
        cs_low();
        xfer(8'h84, 8, rx);
        xfer(8'h55, 8, rx);
        xfer(8'hAA, 4, rx);
        cs_high();
        check("abort_led", led_rgb, 24'h112233);
        check("abort_rxdv_cnt", rx_cnt - rx_base, 2);
        check("abort_done_cnt", done_cnt - done_base, 1);
        check("abort_last_rx", rx_byte, 8'h55);

        // Overrun: 7-byte frame, index saturates
        cs_low();
        for (int b = 0; b < 7; b++) begin
            xfer(8'h00, 8, rx);
            check($sformatf("over_byte%0d", b), rx, exp_over[b]);
        end
        cs_high();

        // Reset during byte 2
        cs_low();
        xfer(8'h84, 8, rx);
        xfer(8'h01, 8, rx);
        xfer(8'h02, 3, rx);
        rst_n = 1'b0;
        #1;
        check("midrst_oe", spi.miso_oe, 1'b0);
        check("midrst_miso", spi.miso, 1'b0);
        check("midrst_led", led_rgb, 24'h0);
        check("midrst_rx_byte", rx_byte, 8'h00);
        check("midrst_rx_dv", rx_dv, 1'b0);
        check("midrst_done", frame_done, 1'b0);
        wait_clks(2);
        spi.cs_n = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(5);
        x_pos = 10'h0F0;
        done_base = done_cnt;
        cs_low();
        xfer(8'h00, 8, rx);
        check("postrst_byte0", rx, 8'hF0);
        xfer(8'h00, 8, rx);
        check("postrst_byte1", rx, 8'h00);
        cs_high();
        check("postrst_done_cnt", done_cnt - done_base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
